// File: rtl/parity_check_if.sv
// parity_check_if: serial bit input plus frame status outputs of the parity checker
interface parity_check_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              w;
  logic              w_vld;
  logic [DATA_W-1:0] data;
  logic              done;
  logic              par_err;
  logic              frm_err;
  logic              busy;
  logic              z;
  logic [CNT_W-1:0]  err_cnt;
  modport master (output w, w_vld, input data, done, par_err, frm_err, busy, z, err_cnt);
  modport slave  (input w, w_vld, output data, done, par_err, frm_err, busy, z, err_cnt);
endinterface

// File: rtl/parity_check.sv
// parity_check: receives start/data/parity/stop frames, checks parity and framing
module parity_check #(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b0,
  parameter int CNT_W  = 8
) (
  input logic           clk,
  input logic           rst,
  parity_check_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
  state_t            state, nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] sh, data;
  logic [CNT_W-1:0]  err_cnt;
  logic              z, perr, done, par_err, frm_err;
  assign bus.data    = data;
  assign bus.done    = done;
  assign bus.par_err = par_err;
  assign bus.frm_err = frm_err;
  assign bus.busy    = state != IDLE;
  assign bus.z       = z;
  assign bus.err_cnt = err_cnt;
  // state register; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= nxt;
  // next state advances only on qualified bits, so w_vld=0 stalls the frame
  always_comb begin
    nxt = state;
    if (bus.w_vld)
      case (state)
        IDLE:    nxt = bus.w ? DATA : IDLE;
        DATA:    nxt = (cnt == CW'(DATA_W - 1)) ? PAR : DATA;
        PAR:     nxt = STOP;
        default: nxt = IDLE;
      endcase
  end
  // frame datapath: shift in data, track parity, publish status one clk after the stop bit
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt     <= '0;
      sh      <= '0;
      data    <= '0;
      z       <= 1'b0;
      perr    <= 1'b0;
      done    <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      done    <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      if (bus.w_vld)
        case (state)
          IDLE: if (bus.w) begin
            z   <= 1'b0;
            cnt <= '0;
          end
          DATA: begin
            sh[cnt] <= bus.w;
            z       <= z ^ bus.w;
            cnt     <= cnt + 1'b1;
          end
          PAR: perr <= bus.w != (z ^ ODD);
          default: begin
            done    <= 1'b1;
            par_err <= perr;
            frm_err <= bus.w;
            data    <= sh;
            if ((perr | bus.w) && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end
        endcase
    end
endmodule

// File: tb/tb_parity_check.sv
// tb_parity_check: randomized frames against a bit-list model for even (u0) and odd (u1) checkers
module tb_parity_check;
  logic clk = 1'b0, rst = 1'b0, w = 1'b0, w_vld = 1'b0;
  always #5 clk = ~clk;
  parity_check_if #(.DATA_W(8), .CNT_W(8)) b0 ();
  parity_check_if #(.DATA_W(8), .CNT_W(2)) b1 ();
  assign b0.w = w;
  assign b0.w_vld = w_vld;
  assign b1.w = w;
  assign b1.w_vld = w_vld;
  parity_check #(.DATA_W(8), .ODD(1'b0), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  parity_check #(.DATA_W(8), .ODD(1'b1), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  logic [7:0] o_data[2], o_cnt[2];
  logic o_done[2], o_pe[2], o_fe[2], o_busy[2], o_z[2];
  assign o_data[0] = b0.data;
  assign o_data[1] = b1.data;
  assign o_cnt[0]  = b0.err_cnt;
  assign o_cnt[1]  = 8'(b1.err_cnt);
  assign o_done[0] = b0.done;
  assign o_done[1] = b1.done;
  assign o_pe[0]   = b0.par_err;
  assign o_pe[1]   = b1.par_err;
  assign o_fe[0]   = b0.frm_err;
  assign o_fe[1]   = b1.frm_err;
  assign o_busy[0] = b0.busy;
  assign o_busy[1] = b1.busy;
  assign o_z[0]    = b0.z;
  assign o_z[1]    = b1.z;
  int total = 0, bad = 0, ndone = 0;
  int nb;
  logic [10:0] fr;
  logic [7:0] m_data;
  logic m_done, m_fe, m_z;
  logic m_pe[2];
  int m_cnt[2];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_clear();
    nb = 0;
    fr = '0;
    m_data = '0;
    m_done = 0;
    m_fe = 0;
    m_z = 0;
    for (int k = 0; k < 2; k++) begin
      m_pe[k] = 0;
      m_cnt[k] = 0;
    end
  endtask
  task automatic model_step(logic v, logic b);
    m_done = 0;
    m_fe = 0;
    m_pe[0] = 0;
    m_pe[1] = 0;
    if (v && (nb > 0 || b)) begin
      fr[nb] = b;
      nb++;
      if (nb <= 9) begin
        m_z = 0;
        for (int i = 1; i < nb; i++) m_z ^= fr[i];
      end
      if (nb == 11) begin
        m_data = fr[8:1];
        m_done = 1;
        m_fe = fr[10];
        for (int k = 0; k < 2; k++) begin
          m_pe[k] = (($countones(fr[8:1]) + int'(fr[9]) + k) % 2) != 0;
          if ((m_pe[k] || m_fe) && m_cnt[k] < (k == 1 ? 3 : 255)) m_cnt[k]++;
        end
        nb = 0;
      end
    end
  endtask
  task automatic step(logic v, logic b);
    w_vld = v;
    w = b;
    @(posedge clk);
    model_step(v, b);
    @(negedge clk);
  endtask
  task automatic sb(logic b, int gap_pct);
    if ($urandom_range(99) < gap_pct) step(1'b0, 1'($urandom_range(1)));
    step(1'b1, b);
  endtask
  task automatic frame(int idle, logic [7:0] d, logic p, logic s, int gap_pct);
    for (int i = 0; i < idle; i++) sb(1'b0, gap_pct);
    sb(1'b1, gap_pct);
    for (int i = 0; i < 8; i++) sb(d[i], gap_pct);
    sb(p, gap_pct);
    sb(s, gap_pct);
  endtask
  task automatic do_reset();
    #2;
    w_vld = 0;
    rst = 0;
    model_clear();
    #1;
    chk("rst_data", b0.data, 0);
    chk("rst_done", b0.done, 0);
    chk("rst_busy", b0.busy, 0);
    chk("rst_z", b0.z, 0);
    chk("rst_cnt", b0.err_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1;
  endtask
  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("data%0d", k), o_data[k], m_data);
        chk($sformatf("done%0d", k), o_done[k], m_done);
        chk($sformatf("par_err%0d", k), o_pe[k], m_pe[k]);
        chk($sformatf("frm_err%0d", k), o_fe[k], m_fe);
        chk($sformatf("busy%0d", k), o_busy[k], nb > 0);
        chk($sformatf("z%0d", k), o_z[k], m_z);
        chk($sformatf("err_cnt%0d", k), o_cnt[k], m_cnt[k]);
      end
      if (o_done[1]) ndone++;
    end
  end
  initial begin
    logic [1:0] seq [5];
    seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    repeat (2) @(negedge clk);
    chk("init_data", b0.data, 0);
    chk("init_busy", b0.busy, 0);
    chk("init_cnt", b0.err_cnt, 0);
    rst = 1;
    frame(0, 8'hA5, 1'b0, 1'b0, 0);
    chk("a5_done", b0.done, 1);
    chk("a5_data", b0.data, 8'hA5);
    chk("a5_pe", b0.par_err, 0);
    chk("a5_fe", b0.frm_err, 0);
    chk("a5_cnt", b0.err_cnt, 0);
    chk("a5_pe_odd", b1.par_err, 1);
    frame(0, 8'hA5, 1'b1, 1'b0, 0);
    chk("a5p1_pe", b0.par_err, 1);
    chk("a5p1_data", b0.data, 8'hA5);
    chk("a5p1_cnt", b0.err_cnt, 1);
    frame(0, 8'h01, 1'b1, 1'b1, 0);
    chk("01_pe", b0.par_err, 0);
    chk("01_fe", b0.frm_err, 1);
    chk("01_cnt", b0.err_cnt, 2);
    do_reset();
    frame(0, 8'h03, 1'b1, 1'b0, 0);
    chk("odd_ok_pe", b1.par_err, 0);
    chk("odd_ok_done", b1.done, 1);
    frame(0, 8'h03, 1'b0, 1'b0, 0);
    chk("odd_bad_pe", b1.par_err, 1);
    chk("odd_bad_cnt", b1.err_cnt, 1);
    frame(3, 8'h3C, 1'b0, 1'b0, 100);
    chk("3c_data", b0.data, 8'h3C);
    chk("3c_pe", b0.par_err, 0);
    chk("3c_z", b0.z, 0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    chk("mid_busy", b0.busy, 1);
    chk("mid_z", b0.z, 0);
    do_reset();
    frame(0, 8'hFF, 1'b0, 1'b0, 0);
    chk("ff_data", b0.data, 8'hFF);
    chk("ff_pe", b0.par_err, 0);
    chk("ff_pe_odd", b1.par_err, 1);
    do_reset();
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      frame(0, 8'h03, 1'b0, 1'b0, 0);
      chk($sformatf("sat_cnt%0d", i), b1.err_cnt, seq[i]);
      chk($sformatf("sat_done%0d", i), b1.done, 1);
    end
    step(1'b0, 1'b0);
    chk("sat_ndone", ndone, 5);
    repeat (150) begin
      if ($urandom_range(19) == 0) begin
        step(1'b1, 1'b1);
        repeat ($urandom_range(9)) step(1'($urandom_range(1)), 1'($urandom_range(1)));
        do_reset();
      end else begin
        frame($urandom_range(2), 8'($urandom), 1'($urandom_range(1)),
              $urandom_range(3) == 0, $urandom_range(50));
      end
    end
    repeat (2) step(1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
